// File: rtl/atsc_rx_stage_ctrl.sv
// atsc_rx_stage_ctrl: routes samples from axi_wrapper either through the HLS kernel
// (KERNEL) or straight to the output (BYPASS). Mode changes go through DRAIN, which
// waits until the kernel is empty and the output register has drained.
// Optional macro ATSC_RX_STAGE_CNT_EN adds 32-bit input/output beat counters
// on readback 2/3; without it those addresses read 0.
// Readback 4 layout: {state, in-flight}, state KERNEL=0, DRAIN=1, BYPASS=2.
module atsc_rx_stage_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SR_BASE    = 128,
    parameter int unsigned INFLIGHT_W = 10
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic [7:0]        rb_addr,
    output logic [63:0]       rb_data,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] k_out_tdata,
    output logic              k_out_tlast,
    output logic              k_out_tvalid,
    input  logic              k_out_tready,
    input  logic [DATA_W-1:0] k_in_tdata,
    input  logic              k_in_tlast,
    input  logic              k_in_tvalid,
    output logic              k_in_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
);

    typedef enum logic [1:0] {
        ST_KERNEL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_BYPASS = 2'd2
    } state_e;

    localparam logic [7:0]            ADDR_CTRL    = 8'(SR_BASE);
    localparam logic [7:0]            ADDR_SPP     = 8'(SR_BASE + 1);
    localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = '1;

    state_e                state_q, state_d;
    logic                  drain_byp_q, drain_byp_d;   // draining out of BYPASS: kernel returns are stragglers
    logic [31:0]           ctrl_q, ctrl_d;
    logic [15:0]           spp_q, spp_d;
    logic [15:0]           bpp_q, bpp_d;
    logic [INFLIGHT_W-1:0] infl_q, infl_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [63:0]           rb_q, rb_d;

    logic                  en, byp, out_free, infl_full;
    logic                  src_vld, src_last, load, kout_hs, kin_hs, m_hs;
    logic [DATA_W-1:0]     src_data;

    // Mode FSM, stream routing, in-flight tracking, output register and settings decode
    always_comb begin
        en          = ctrl_q[0];
        byp         = ctrl_q[1];
        out_free    = !out_vld_q || m_tready;
        infl_full   = (infl_q == INFLIGHT_MAX);
        s_tready    = 1'b0;
        k_out_tvalid = 1'b0;
        k_out_tdata = s_tdata;
        k_out_tlast = s_tlast;
        k_in_tready = 1'b0;
        src_vld     = 1'b0;
        src_data    = s_tdata;
        src_last    = s_tlast;
        state_d     = state_q;
        drain_byp_d = drain_byp_q;

        case (state_q)
            ST_KERNEL: begin
                k_out_tvalid = s_tvalid && en && !byp && !infl_full;
                s_tready     = k_out_tready && en && !byp && !infl_full;
                k_in_tready  = out_free;
                src_vld      = k_in_tvalid;
                src_data     = k_in_tdata;
                src_last     = k_in_tlast;
                if (byp) begin
                    state_d     = ST_DRAIN;
                    drain_byp_d = 1'b0;
                end
            end
            ST_BYPASS: begin
                s_tready    = en && byp && out_free;
                k_in_tready = 1'b1;
                src_vld     = s_tvalid && en && byp;
                if (!byp) begin
                    state_d     = ST_DRAIN;
                    drain_byp_d = 1'b1;
                end
            end
            default: begin
                if (drain_byp_q) begin
                    k_in_tready = 1'b1;
                end else begin
                    k_in_tready = out_free;
                    src_vld     = k_in_tvalid;
                    src_data    = k_in_tdata;
                    src_last    = k_in_tlast;
                end
                if (infl_q == '0 && !out_vld_q) begin
                    state_d = byp ? ST_BYPASS : ST_KERNEL;
                end
            end
        endcase

        if (!ap_rst_n) begin
            s_tready     = 1'b0;
            k_out_tvalid = 1'b0;
            k_in_tready  = 1'b0;
            src_vld      = 1'b0;
        end

        kout_hs = k_out_tvalid && k_out_tready;
        kin_hs  = k_in_tvalid && k_in_tready;
        m_hs    = out_vld_q && m_tready;
        load    = src_vld && out_free;

        infl_d = infl_q;
        if (kout_hs && !kin_hs) begin
            infl_d = infl_q + INFLIGHT_W'(1);
        end else if (!kout_hs && kin_hs && infl_q != '0) begin
            infl_d = infl_q - INFLIGHT_W'(1);
        end

        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        bpp_d      = bpp_q;
        if (m_hs) begin
            out_vld_d = 1'b0;
        end
        if (load) begin
            out_vld_d  = 1'b1;
            out_data_d = src_data;
            if (spp_q == 16'd0) begin
                out_last_d = src_last;
            end else if (bpp_q + 16'd1 == spp_q) begin
                out_last_d = 1'b1;
                bpp_d      = 16'd0;
            end else begin
                out_last_d = 1'b0;
                bpp_d      = bpp_q + 16'd1;
            end
        end

        ctrl_d = ctrl_q;
        spp_d  = spp_q;
        if (set_stb && set_addr == ADDR_CTRL) begin
            ctrl_d = set_data;
        end
        if (set_stb && set_addr == ADDR_SPP) begin
            spp_d = set_data[15:0];
            bpp_d = 16'd0;
        end
    end

`ifdef ATSC_RX_STAGE_CNT_EN
    logic        s_hs;
    logic [31:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

    // Wrapping beat counters on the input and output streams
    always_comb begin
        s_hs      = s_tvalid && s_tready;
        in_cnt_d  = in_cnt_q + 32'(s_hs);
        out_cnt_d = out_cnt_q + 32'(m_hs);
    end

    // Beat counter registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_cnt_q  <= 32'd0;
            out_cnt_q <= 32'd0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end
`endif

    // Readback mux
    always_comb begin
        case (rb_addr)
            8'd0:    rb_d = {32'd0, ctrl_q};
            8'd1:    rb_d = {48'd0, spp_q};
`ifdef ATSC_RX_STAGE_CNT_EN
            8'd2:    rb_d = 64'(in_cnt_q);
            8'd3:    rb_d = 64'(out_cnt_q);
`else
            8'd2:    rb_d = 64'd0;
            8'd3:    rb_d = 64'd0;
`endif
            8'd4:    rb_d = 64'({state_q, infl_q});
            default: rb_d = 64'h0BADC0DE0BADC0DE;
        endcase
    end

    // State, settings and datapath registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_KERNEL;
            drain_byp_q <= 1'b0;
            ctrl_q      <= 32'h1;
            spp_q       <= 16'd0;
            bpp_q       <= 16'd0;
            infl_q      <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            rb_q        <= 64'd0;
        end else begin
            state_q     <= state_d;
            drain_byp_q <= drain_byp_d;
            ctrl_q      <= ctrl_d;
            spp_q       <= spp_d;
            bpp_q       <= bpp_d;
            infl_q      <= infl_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            rb_q        <= rb_d;
        end
    end

    assign m_tvalid = out_vld_q;
    assign m_tdata  = out_data_q;
    assign m_tlast  = out_last_q;
    assign rb_data  = rb_q;

endmodule
